// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: one-outstanding-request fetcher feeding a
// circular prefetch queue of {instr, pc+4} entries, with redirect flushing.

module if_fetch_queue_entry #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk) begin
    if (we_i) q_o <= d_i;
  end
endmodule

module if_fetch_queue #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             dec_ready,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc_next
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pcn;
  } entry_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             pop, push, issue, space;
  logic [CW-1:0]    cnt_after_pop;
  entry_t           push_ent;
  entry_t           ent_q [DEPTH];

  assign instr_valid   = (count_q != '0);
  assign pop           = instr_valid && dec_ready;
  assign cnt_after_pop = count_q - CW'(pop);
  // Reserve a slot at issue time so the eventual push can never overflow.
  assign space         = (cnt_after_pop < CW'(DEPTH));

  // Fetch sequencing; redirect always wins and retargets fetch_pc.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && space) begin
          issue      = 1'b1;
          req_addr_d = fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d = S_IDLE;
          if (!redirect_valid) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + WIDTH'(4);
          end
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign push_ent.instr = imem_rdata;
  assign push_ent.pcn   = req_addr_q + WIDTH'(4);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [2*WIDTH-1:0] q;
    if_fetch_queue_entry #(.W(2*WIDTH)) u_ent (
      .clk  (clk),
      .we_i (push && !redirect_valid && (wr_ptr_q == PW'(i))),
      .d_i  (push_ent),
      .q_o  (q)
    );
    assign ent_q[i] = entry_t'(q);
  end

  // Request is held from the issuing IDLE cycle through WAIT/DROP; gated by
  // rst so it drops as soon as reset asserts.
  assign imem_req  = rst && (issue || (state_q != S_IDLE));
  assign imem_addr = (state_q == S_IDLE) ? fetch_pc_q : req_addr_q;
  assign instr     = ent_q[rd_ptr_q].instr;
  assign pc_next   = ent_q[rd_ptr_q].pcn;

endmodule
